// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for a five-stage ARMv8-subset pipeline.
// Keeps a one-entry shadow of the instruction in EX and saturating event counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             ex_load_q, ex_load_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic is_ldur, is_stur, is_b, is_cbz, is_bcond;
    logic use_rn, use_rm, use_rt;
    logic src_hit, load_use;
    logic unused_bits;

    assign is_ldur  = (id_instr[31:21] == 11'b11111000010);
    assign is_stur  = (id_instr[31:21] == 11'b11111000000);
    assign is_b     = (id_instr[31:26] == 6'b000101);
    assign is_cbz   = (id_instr[31:24] == 8'b10110100);
    assign is_bcond = (id_instr[31:24] == 8'b01010100);

    assign use_rn = ~(is_b | is_bcond | is_cbz);
    assign use_rm = (id_instr[28:25] == 4'b0101);
    assign use_rt = is_stur | is_cbz;

    assign src_hit = (use_rn & (id_instr[9:5]   == ex_rd_q))
                   | (use_rm & (id_instr[20:16] == ex_rd_q))
                   | (use_rt & (id_instr[4:0]   == ex_rd_q));

    assign load_use = (state_q == RUN) & id_valid & ex_load_q
                    & (ex_rd_q != 5'd31) & src_hit;

    // Immediate/shift bits never name a register.
    assign unused_bits = ^id_instr[15:10];

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN, LSTALL: begin
                    if (ex_br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        // A single squashed cycle is covered by the branch cycle itself.
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FLUSH_INIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = LSTALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (ex_br_taken) begin
                        fcnt_d = FLUSH_INIT;
                    end else if (fcnt_q <= 2'd1) begin
                        fcnt_d  = 2'd0;
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - 2'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        ex_load_d   = idex_bubble ? 1'b0 : (id_valid & is_ldur);
        ex_rd_d     = idex_bubble ? 5'd0 : id_instr[4:0];
        stall_cnt_d = (pc_stall && stall_cnt_q != '1)   ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (ifid_flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            fcnt_q      <= 2'd0;
            ex_load_q   <= 1'b0;
            ex_rd_q     <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            ex_load_q   <= ex_load_d;
            ex_rd_q     <= ex_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, corner sequences, and random stimulus
// against a cycle model built from the hazard rules (two instances: FC=2/16b and FC=1/2b).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] id_instr = 32'h0;
    logic        id_valid = 1'b0;
    logic        ex_br_taken = 1'b0;

    logic        a_pc_stall, a_ifid_stall, a_idex_bubble, a_ifid_flush;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_stall, b_ifid_stall, b_idex_bubble, b_ifid_flush;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .ex_br_taken(ex_br_taken), .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall),
        .idex_bubble(a_idex_bubble), .ifid_flush(a_ifid_flush),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .ex_br_taken(ex_br_taken), .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall),
        .idex_bubble(b_idex_bubble), .ifid_flush(b_ifid_flush),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

    localparam logic [31:0] LDUR_X2   = 32'hF8400022; // LDUR X2,[X1]
    localparam logic [31:0] LDUR_X31  = 32'hF840003F; // LDUR X31,[X1]
    localparam logic [31:0] ADD_RN    = 32'h8B040043; // ADD X3,X2,X4
    localparam logic [31:0] ADD_X31   = 32'h8B1F03E3; // ADD X3,X31,X31
    localparam logic [31:0] ADD_RM    = 32'h8B020025; // ADD X5,X1,X2
    localparam logic [31:0] B_IMM     = 32'h14000040; // B with imm bits aliasing Rn=2
    localparam logic [31:0] STUR_X2   = 32'hF8000022; // STUR X2,[X1]
    localparam logic [31:0] CBZ_X2    = 32'hB4000002; // CBZ X2

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int fc_par [2] = '{2, 1};
    int cnt_max[2] = '{65535, 3};
    int m_owed[2];     // flush cycles still owed after the current one
    bit m_stalled[2];  // previous cycle was a load-use stall
    bit m_load[2];
    int m_rd[2];
    int m_sc[2];
    int m_fc[2];

    function automatic bit uses(input logic [31:0] ins, input int r);
        bit branchy = (ins[31:26] == 6'b000101) || (ins[31:24] == 8'h54) || (ins[31:24] == 8'hB4);
        bit rt_src  = (ins[31:21] == 11'b11111000000) || (ins[31:24] == 8'hB4);
        bit hit = 0;
        if (!branchy && int'(ins[9:5]) == r) hit = 1;
        if (ins[28:25] == 4'b0101 && int'(ins[20:16]) == r) hit = 1;
        if (rt_src && int'(ins[4:0]) == r) hit = 1;
        return hit;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owed[k] = 0; m_stalled[k] = 0; m_load[k] = 0; m_rd[k] = 0;
            m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_cycle(input int k, output bit e_st, output bit e_fl, output bit e_bu);
        bit in_flush = (m_owed[k] > 0);
        bit lu = !in_flush && !m_stalled[k] && id_valid && m_load[k] && m_rd[k] != 31
                 && uses(id_instr, m_rd[k]);
        e_fl = ex_br_taken || in_flush;
        e_st = lu && !ex_br_taken;
        e_bu = e_fl || e_st;
        if (ex_br_taken) m_owed[k] = fc_par[k] - 1;
        else if (in_flush) m_owed[k]--;
        m_stalled[k] = e_st;
        if (e_bu) begin
            m_load[k] = 0; m_rd[k] = 0;
        end else begin
            m_load[k] = id_valid && (id_instr[31:21] == 11'b11111000010);
            m_rd[k]   = int'(id_instr[4:0]);
        end
        if (e_st && m_sc[k] < cnt_max[k]) m_sc[k]++;
        if (e_fl && m_fc[k] < cnt_max[k]) m_fc[k]++;
    endtask

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic br);
        id_instr = ins; id_valid = v; ex_br_taken = br;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        #1;
        check("rst_pc_stall", a_pc_stall, 0);
        check("rst_flush", a_ifid_flush, 0);
        check("rst_cnts", {a_stall_cnt, a_flush_cnt}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [4:0] pick_reg();
        int v = $urandom_range(0, 4);
        return (v == 4) ? 5'd31 : 5'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: return {11'b11111000010, r[8:0], 2'b00, pick_reg(), pick_reg()};
            1: return {11'b11111000000, r[8:0], 2'b00, pick_reg(), pick_reg()};
            2: return {11'b10001011000, pick_reg(), r[5:0], pick_reg(), pick_reg()};
            3: return {6'b000101, r[25:0]};
            4: return {8'hB4, r[18:0], pick_reg()};
            default: return {8'h54, r[18:0], 1'b0, r[22:19]};
        endcase
    endfunction

    typedef struct {
        logic [31:0] instr;
        bit valid, br, st, fl, bu;
        int sc, fc;
    } vec_t;

    vec_t tbl[18];

    initial begin
        bit e_st, e_fl, e_bu;

        tbl[0]  = '{LDUR_X2,  1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{ADD_RN,   1, 0, 1, 0, 1, 0, 0};
        tbl[2]  = '{ADD_RN,   1, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{LDUR_X31, 1, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{ADD_X31,  1, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{LDUR_X2,  1, 0, 0, 0, 0, 1, 0};
        tbl[6]  = '{B_IMM,    1, 0, 0, 0, 0, 1, 0};
        tbl[7]  = '{LDUR_X2,  1, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{STUR_X2,  1, 0, 1, 0, 1, 1, 0};
        tbl[9]  = '{STUR_X2,  1, 0, 0, 0, 0, 2, 0};
        tbl[10] = '{LDUR_X2,  1, 0, 0, 0, 0, 2, 0};
        tbl[11] = '{CBZ_X2,   0, 0, 0, 0, 0, 2, 0};
        tbl[12] = '{LDUR_X2,  1, 0, 0, 0, 0, 2, 0};
        tbl[13] = '{CBZ_X2,   1, 1, 0, 1, 1, 2, 0};
        tbl[14] = '{ADD_RM,   1, 0, 0, 1, 1, 2, 1};
        tbl[15] = '{LDUR_X2,  1, 0, 0, 0, 0, 2, 2};
        tbl[16] = '{ADD_RM,   1, 0, 1, 0, 1, 2, 2};
        tbl[17] = '{ADD_RM,   1, 0, 0, 0, 0, 3, 2};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].instr, tbl[i].valid, tbl[i].br);
            @(negedge clk);
            check($sformatf("v%0d_pc_stall", i),   a_pc_stall,   tbl[i].st);
            check($sformatf("v%0d_ifid_stall", i), a_ifid_stall, tbl[i].st);
            check($sformatf("v%0d_flush", i),      a_ifid_flush, tbl[i].fl);
            check($sformatf("v%0d_bubble", i),     a_idex_bubble, tbl[i].bu);
            check($sformatf("v%0d_stall_cnt", i),  a_stall_cnt,  tbl[i].sc);
            check($sformatf("v%0d_flush_cnt", i),  a_flush_cnt,  tbl[i].fc);
            cyc();
        end

        // Reset during the second flush cycle abandons the sequence.
        do_reset();
        drive(LDUR_X2, 1, 0); cyc();
        drive(ADD_RN, 1, 0); #2 check("rf_stall", a_pc_stall, 1); cyc();
        drive(ADD_RN, 1, 1); #2 check("lstall_br_flush", a_ifid_flush, 1);
        check("lstall_br_nostall", a_pc_stall, 0); cyc();
        drive(32'h0, 0, 0); #2 check("rf_second_flush", a_ifid_flush, 1);
        reset = 1'b1; #1;
        check("rf_async_flush", a_ifid_flush, 0);
        check("rf_async_bubble", a_idex_bubble, 0);
        check("rf_async_cnts", {a_stall_cnt, a_flush_cnt}, 0);
        cyc(); cyc(); reset = 1'b0;
        drive(ADD_RN, 1, 0); #2 check("rf_after_quiet", {a_pc_stall, a_ifid_flush}, 0); cyc();
        drive(LDUR_X2, 1, 0); cyc();
        drive(ADD_RN, 1, 0); #2 check("rf_run_stall", a_pc_stall, 1); cyc();

        // Reset during LSTALL.
        do_reset();
        drive(LDUR_X2, 1, 0); cyc();
        drive(ADD_RN, 1, 0); cyc();
        #2 reset = 1'b1; #1;
        check("rl_async_cnt", a_stall_cnt, 0);
        check("rl_async_out", {a_pc_stall, a_idex_bubble}, 0);
        cyc(); cyc(); reset = 1'b0;
        drive(ADD_RN, 1, 0); #2 check("rl_after", {a_pc_stall, a_idex_bubble}, 0); cyc();

        // Back-to-back taken branches reload the flush counter; FC=1 instance never enters FLUSH.
        do_reset();
        drive(32'h0, 0, 1); #2 check("rel_a0", a_ifid_flush, 1); cyc();
        drive(32'h0, 0, 1); #2 check("rel_a1", a_ifid_flush, 1);
        check("rel_b1", b_ifid_flush, 1); cyc();
        drive(32'h0, 0, 0); #2 check("rel_a2", a_ifid_flush, 1);
        check("rel_b2_skip", b_ifid_flush, 0); cyc();
        #2 check("rel_a3_done", a_ifid_flush, 0);
        check("rel_a_cnt", a_flush_cnt, 3);
        check("rel_b_cnt", b_flush_cnt, 2);

        // Four load-use pairs: 2-bit counter saturates, 16-bit keeps counting.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            drive(LDUR_X2, 1, 0); cyc();
            drive(ADD_RN, 1, 0); cyc();
            cyc();
        end
        #2 check("sat_b_stall_cnt", b_stall_cnt, 3);
        check("sat_a_stall_cnt", a_stall_cnt, 4);

        // Random stimulus against the model, both instances.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            drive(rand_instr(), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 12));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("r%0d_%0d_sc", c, k), (k == 0) ? 32'(a_stall_cnt) : 32'(b_stall_cnt), m_sc[k]);
                check($sformatf("r%0d_%0d_fc", c, k), (k == 0) ? 32'(a_flush_cnt) : 32'(b_flush_cnt), m_fc[k]);
                model_cycle(k, e_st, e_fl, e_bu);
                check($sformatf("r%0d_%0d_pc", c, k), (k == 0) ? a_pc_stall : b_pc_stall, e_st);
                check($sformatf("r%0d_%0d_if", c, k), (k == 0) ? a_ifid_stall : b_ifid_stall, e_st);
                check($sformatf("r%0d_%0d_fl", c, k), (k == 0) ? a_ifid_flush : b_ifid_flush, e_fl);
                check($sformatf("r%0d_%0d_bu", c, k), (k == 0) ? a_idex_bubble : b_idex_bubble, e_bu);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning cycles squashed after a taken branch (legal 1..3).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the stall/flush counters.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_instr  input  32  instruction currently in the IF/ID register.
REQ-006 id_valid  input  1  id_instr holds a real instruction (0 = bubble).
REQ-007 ex_br_taken  input  1  one-cycle pulse: branch in EX resolved taken.
REQ-008 pc_stall  output  1  hold PC this cycle.
REQ-009 ifid_stall  output  1  hold IF/ID register this cycle.
REQ-010 idex_bubble  output  1  load all-zero NOP into ID/EX instead of the decoded instruction.
REQ-011 ifid_flush  output  1  replace IF/ID contents with 32'h00000000.
REQ-012 stall_cnt  output  CNT_W  saturating count of load-use stall cycles.
REQ-013 flush_cnt  output  CNT_W  saturating count of branch-flush cycles.

Function
REQ-014 Decode of id_instr SHALL be: LDUR = [31:21] 11111000010; STUR = [31:21] 11111000000; B = [31:26] 000101; CBZ = [31:24] 10110100; B.cond = [31:24] 01010100.
REQ-015 Source registers SHALL be: Rn [9:5] for all except B, B.cond, CBZ; Rm [20:16] when [28:25] = 0101; Rt [4:0] for STUR and CBZ.
REQ-016 An EX shadow (ex_load, ex_rd[4:0]) SHALL capture (id_valid & LDUR, id_instr[4:0]) each posedge on which idex_bubble = 0, and SHALL be cleared to (0, 0) on any posedge on which idex_bubble = 1.
REQ-017 load_use SHALL be: state RUN & id_valid & ex_load & ex_rd != 31 & (any used source field == ex_rd).
REQ-018 FSM states SHALL be RUN, LSTALL, FLUSH; reset state RUN.
REQ-019 RUN: ex_br_taken -> FLUSH with flush counter loaded to FLUSH_CYCLES-1; otherwise load_use -> LSTALL; otherwise stay RUN.
REQ-020 In RUN with load_use and no ex_br_taken, pc_stall = ifid_stall = idex_bubble = 1 in the same cycle (combinational).
REQ-021 LSTALL SHALL last exactly one cycle with all outputs deasserted (forwarding covers the load), then return to RUN; ex_br_taken in LSTALL -> FLUSH.
REQ-022 In any cycle with ex_br_taken = 1: ifid_flush = idex_bubble = 1, pc_stall = ifid_stall = 0; branch takes priority over load_use.
REQ-023 FLUSH: ifid_flush = idex_bubble = 1 each cycle; counter decrements; at 0 -> RUN; a new ex_br_taken in FLUSH reloads the counter to FLUSH_CYCLES-1.
REQ-024 With FLUSH_CYCLES = 1, the FLUSH state SHALL be skipped (RUN -> RUN).
REQ-025 stall_cnt SHALL increment on each cycle with pc_stall = 1; flush_cnt on each cycle with ifid_flush = 1; both saturate at all-ones, never wrap.
REQ-026 id_valid = 0 SHALL never cause load_use.

Reset
REQ-027 reset = 1 SHALL immediately force state RUN, shadow (0, 0), flush counter 0, stall_cnt = flush_cnt = 0 and all control outputs 0 without waiting for clk.
REQ-028 Reset asserted mid-FLUSH or mid-LSTALL SHALL abandon the sequence; first cycle after release is RUN with no carry-over.

Verification
REQ-029 LDUR X2,[X1] then ADD X3,X2,X4 -> one cycle with pc_stall = ifid_stall = idex_bubble = 1, next cycle all 0, stall_cnt = 1.
REQ-030 LDUR X31 then ADD using X31; LDUR X2 then B -> no stall, stall_cnt = 0.
REQ-031 ex_br_taken pulse, FLUSH_CYCLES = 2 -> ifid_flush = idex_bubble = 1 for exactly 2 cycles, flush_cnt = 2.
REQ-032 ex_br_taken in the same cycle as load_use -> flush outputs only, pc_stall = 0, stall_cnt unchanged.
REQ-033 Reset asserted during the second FLUSH cycle -> outputs 0 asynchronously, both counters 0, RUN after release.
REQ-034 CNT_W = 2, four consecutive load-use pairs -> stall_cnt reaches 3 and holds.
